id_ex: RTL and testbench
========================

ID_EX -- requirements
Module: id_ex

Interface
REQ-001 The block SHALL use one clock and one reset with this port order: clk, rst_n, then the remaining ports.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 flush  in  1  discard the ID-stage instruction and load a bubble (taken branch or jump).
REQ-005 stall  in  1  load-use hazard; load a bubble into EX.
REQ-006 hold  in  1  freeze all registers, for example on a downstream memory wait.
REQ-007 id_valid  in  1  the ID stage holds a real instruction.
REQ-008 jump_in 2, branch_in 1, mem_read_in 1, mem_to_reg_in 2, mem_write_in 1, alu_src_in 1, reg_write_in 1, reg_dst_in 2, alu_op_in 4  in  control fields from the ctrl decoder.
REQ-009 rs_data_in 32, rt_data_in 32, imm_in 32, pc4_in 32, rs_in 5, rt_in 5, rd_in 5, shamt_in 5  in  ID-stage operands.
REQ-010 Each _in port SHALL have a matching registered _out port of the same width, direction out.
REQ-011 ex_valid  out  1  EX holds a real instruction.
REQ-012 bubble_cnt  out  16  bubble counter; present only when the configuration macro is defined.

Function
REQ-013 All outputs SHALL be registered, with a latency of 1 clk from the _in ports to the _out ports.
REQ-014 Each rising edge SHALL apply exactly one action, in priority order: flush > stall > hold > load.
REQ-015 LOAD (none of flush, stall or hold asserted) SHALL capture every _in field, and ex_valid SHALL take id_valid.
REQ-016 BUBBLE (flush or stall) SHALL:
- clear jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_dst, alu_op and ex_valid to 0;
- leave the data fields don't-care, with the implementation driving them to 0.
REQ-017 HOLD (hold asserted, flush and stall both low) SHALL keep every output unchanged.
REQ-018 When flush and hold are both asserted, the block SHALL insert a bubble, because flush beats hold.
REQ-019 When stall and hold are both asserted, the block SHALL insert a bubble.
REQ-020 When id_valid is 0 in a LOAD cycle, the block SHALL capture the fields as presented and set ex_valid to 0.
REQ-021 The block SHALL NOT modify any field; it is a pure pipeline register with bubble insertion.
REQ-022 A bubble in EX SHALL perform no register write and no memory access: reg_write_out, mem_write_out and mem_read_out are all 0.

Reset
REQ-023 Asserting rst_n low SHALL, immediately and without waiting for clk, force every output to 0, including ex_valid and bubble_cnt.
REQ-024 Reset deassertion SHALL take effect on the first rising clk edge at which rst_n is high.
REQ-025 A reset asserted mid-hold SHALL discard the held contents.

Configuration
REQ-026 When ID_EX_BUBBLE_CNT_EN is defined:
- bubble_cnt SHALL increment by 1 on every BUBBLE edge;
- it SHALL saturate at 16'hFFFF;
- HOLD and LOAD edges SHALL leave it unchanged;
- reset SHALL clear it to 0.
REQ-027 When ID_EX_BUBBLE_CNT_EN is undefined, the bubble_cnt port and its counter logic SHALL be absent, with all other behaviour identical.

Verification
REQ-028 Reset check: hold rst_n low with random inputs -> all outputs 0 asynchronously, before any clk edge.
REQ-029 Single load: present lw controls (mem_read_in=1, mem_to_reg_in=2'b01, alu_src_in=1, reg_write_in=1, alu_op_in=4'h2), rt_in=5'd8, imm_in=32'h10, id_valid=1; clock once -> identical _out values and ex_valid=1 after one edge.
REQ-030 Stall: apply a load-use stall with reg_write_in=1 and alu_op_in=4'h6 -> all control outputs 0, ex_valid=0, and bubble_cnt=1 when ID_EX_BUBBLE_CNT_EN is defined.
REQ-031 Hold: hold=1 for 3 edges while the inputs change -> outputs keep their pre-hold values; a LOAD on the next edge captures the new inputs.
REQ-032 Priority: flush=1, stall=1, hold=1 together with branch_in=1 -> bubble with branch_out=0; then hold=1 alone -> the bubble is retained.
REQ-033 Saturation (macro defined): apply 65540 consecutive stall edges -> bubble_cnt=16'hFFFF; then assert rst_n low -> bubble_cnt=0.

Source files
------------

// File: rtl/id_ex_if.sv
// ID/EX pipeline register interface: ID-stage controls/operands in, EX-stage copies out.
interface id_ex_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  logic              flush;
  logic              stall;
  logic              hold;
  logic              id_valid;

  logic [1:0]        jump_in;
  logic              branch_in;
  logic              mem_read_in;
  logic [1:0]        mem_to_reg_in;
  logic              mem_write_in;
  logic              alu_src_in;
  logic              reg_write_in;
  logic [1:0]        reg_dst_in;
  logic [3:0]        alu_op_in;
  logic [DATA_W-1:0] rs_data_in;
  logic [DATA_W-1:0] rt_data_in;
  logic [DATA_W-1:0] imm_in;
  logic [DATA_W-1:0] pc4_in;
  logic [REG_W-1:0]  rs_in;
  logic [REG_W-1:0]  rt_in;
  logic [REG_W-1:0]  rd_in;
  logic [REG_W-1:0]  shamt_in;

  logic              ex_valid;
  logic [1:0]        jump_out;
  logic              branch_out;
  logic              mem_read_out;
  logic [1:0]        mem_to_reg_out;
  logic              mem_write_out;
  logic              alu_src_out;
  logic              reg_write_out;
  logic [1:0]        reg_dst_out;
  logic [3:0]        alu_op_out;
  logic [DATA_W-1:0] rs_data_out;
  logic [DATA_W-1:0] rt_data_out;
  logic [DATA_W-1:0] imm_out;
  logic [DATA_W-1:0] pc4_out;
  logic [REG_W-1:0]  rs_out;
  logic [REG_W-1:0]  rt_out;
  logic [REG_W-1:0]  rd_out;
  logic [REG_W-1:0]  shamt_out;

  modport master (
    output flush, stall, hold, id_valid,
           jump_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in,
           alu_src_in, reg_write_in, reg_dst_in, alu_op_in,
           rs_data_in, rt_data_in, imm_in, pc4_in, rs_in, rt_in, rd_in, shamt_in,
    input  ex_valid,
           jump_out, branch_out, mem_read_out, mem_to_reg_out, mem_write_out,
           alu_src_out, reg_write_out, reg_dst_out, alu_op_out,
           rs_data_out, rt_data_out, imm_out, pc4_out, rs_out, rt_out, rd_out, shamt_out
  );

  modport slave (
    input  flush, stall, hold, id_valid,
           jump_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in,
           alu_src_in, reg_write_in, reg_dst_in, alu_op_in,
           rs_data_in, rt_data_in, imm_in, pc4_in, rs_in, rt_in, rd_in, shamt_in,
    output ex_valid,
           jump_out, branch_out, mem_read_out, mem_to_reg_out, mem_write_out,
           alu_src_out, reg_write_out, reg_dst_out, alu_op_out,
           rs_data_out, rt_data_out, imm_out, pc4_out, rs_out, rt_out, rd_out, shamt_out
  );
endinterface

// File: rtl/id_ex.sv
// ID/EX pipeline register with bubble insertion (flush > stall > hold > load).
// Optional saturating bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_if.slave      bus
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0] bubble_cnt
`endif
);

  logic bubble;
  assign bubble = bus.flush | bus.stall;

  // Pipeline register: a bubble zeroes everything, hold freezes, otherwise load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid       <= 1'b0;
      bus.jump_out       <= '0;
      bus.branch_out     <= 1'b0;
      bus.mem_read_out   <= 1'b0;
      bus.mem_to_reg_out <= '0;
      bus.mem_write_out  <= 1'b0;
      bus.alu_src_out    <= 1'b0;
      bus.reg_write_out  <= 1'b0;
      bus.reg_dst_out    <= '0;
      bus.alu_op_out     <= '0;
      bus.rs_data_out    <= '0;
      bus.rt_data_out    <= '0;
      bus.imm_out        <= '0;
      bus.pc4_out        <= '0;
      bus.rs_out         <= '0;
      bus.rt_out         <= '0;
      bus.rd_out         <= '0;
      bus.shamt_out      <= '0;
    end else if (bubble) begin
      bus.ex_valid       <= 1'b0;
      bus.jump_out       <= '0;
      bus.branch_out     <= 1'b0;
      bus.mem_read_out   <= 1'b0;
      bus.mem_to_reg_out <= '0;
      bus.mem_write_out  <= 1'b0;
      bus.alu_src_out    <= 1'b0;
      bus.reg_write_out  <= 1'b0;
      bus.reg_dst_out    <= '0;
      bus.alu_op_out     <= '0;
      bus.rs_data_out    <= '0;
      bus.rt_data_out    <= '0;
      bus.imm_out        <= '0;
      bus.pc4_out        <= '0;
      bus.rs_out         <= '0;
      bus.rt_out         <= '0;
      bus.rd_out         <= '0;
      bus.shamt_out      <= '0;
    end else if (!bus.hold) begin
      bus.ex_valid       <= bus.id_valid;
      bus.jump_out       <= bus.jump_in;
      bus.branch_out     <= bus.branch_in;
      bus.mem_read_out   <= bus.mem_read_in;
      bus.mem_to_reg_out <= bus.mem_to_reg_in;
      bus.mem_write_out  <= bus.mem_write_in;
      bus.alu_src_out    <= bus.alu_src_in;
      bus.reg_write_out  <= bus.reg_write_in;
      bus.reg_dst_out    <= bus.reg_dst_in;
      bus.alu_op_out     <= bus.alu_op_in;
      bus.rs_data_out    <= bus.rs_data_in;
      bus.rt_data_out    <= bus.rt_data_in;
      bus.imm_out        <= bus.imm_in;
      bus.pc4_out        <= bus.pc4_in;
      bus.rs_out         <= bus.rs_in;
      bus.rt_out         <= bus.rt_in;
      bus.rd_out         <= bus.rd_in;
      bus.shamt_out      <= bus.shamt_in;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  localparam int unsigned CNT_W = 16;

  // Saturating count of inserted bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex.sv
// Directed self-checking bench for id_ex; saturation scenario runs when ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex;
  localparam int unsigned CTRL_W = 15;
  localparam int unsigned DATA_W = 148;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_ex_if bus ();

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
  id_ex dut (.clk(clk), .rst_n(rst_n), .bus(bus), .bubble_cnt(bubble_cnt));
`else
  id_ex dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // ctrl = {jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_dst, alu_op}
  // data = {rs_data, rt_data, imm, pc4, rs, rt, rd, shamt}
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] data_out;
  assign ctrl_out = {bus.jump_out, bus.branch_out, bus.mem_read_out, bus.mem_to_reg_out,
                     bus.mem_write_out, bus.alu_src_out, bus.reg_write_out, bus.reg_dst_out,
                     bus.alu_op_out};
  assign data_out = {bus.rs_data_out, bus.rt_data_out, bus.imm_out, bus.pc4_out,
                     bus.rs_out, bus.rt_out, bus.rd_out, bus.shamt_out};

  localparam logic [CTRL_W-1:0] CTRL_LW = 15'b00_0_1_01_0_1_1_00_0010;
  localparam logic [DATA_W-1:0] DATA_LW = {32'h1111_2222, 32'h3333_4444, 32'h0000_0010,
                                           32'h0040_0004, 5'd0, 5'd8, 5'd0, 5'd0};
  localparam logic [CTRL_W-1:0] CTRL_ST = 15'b00_0_0_00_0_0_1_00_0110;
  localparam logic [CTRL_W-1:0] CTRL_A  = 15'h5A5A;
  localparam logic [DATA_W-1:0] DATA_A  = {32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003,
                                           32'hA5A5_0004, 5'd1, 5'd2, 5'd3, 5'd4};
  localparam logic [CTRL_W-1:0] CTRL_B  = 15'h25A5;
  localparam logic [DATA_W-1:0] DATA_B  = {32'h5A5A_1000, 32'h5A5A_2000, 32'h5A5A_3000,
                                           32'h5A5A_4000, 5'd31, 5'd17, 5'd9, 5'd22};
  localparam logic [CTRL_W-1:0] CTRL_BR = 15'h1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic v);
    {bus.jump_in, bus.branch_in, bus.mem_read_in, bus.mem_to_reg_in, bus.mem_write_in,
     bus.alu_src_in, bus.reg_write_in, bus.reg_dst_in, bus.alu_op_in} = c;
    {bus.rs_data_in, bus.rt_data_in, bus.imm_in, bus.pc4_in,
     bus.rs_in, bus.rt_in, bus.rd_in, bus.shamt_in} = d;
    bus.id_valid = v;
  endtask

  task automatic set_ctl(input logic f, input logic s, input logic h);
    bus.flush = f;
    bus.stall = s;
    bus.hold  = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] rnd;
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b1;
    set_ctl(1'($urandom), 1'($urandom), 1'($urandom));
    set_in(CTRL_W'($urandom), rnd, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl_out !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %h expected 0", ctrl_out);
    end
    checks++;
    if (data_out !== '0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", data_out);
    end
    checks++;
    if (bus.ex_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ex_valid: got %b expected 0", bus.ex_valid);
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    checks++;
    if (bubble_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_bubble_cnt: got %h expected 0", bubble_cnt);
    end
`endif
    repeat (2) tick();
    checks++;
    if (data_out !== '0) begin
      errors++; $display("FAIL reset_held_data: got %h expected 0", data_out);
    end
    set_ctl(1'b0, 1'b0, 1'b0);
    set_in('0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_load();
    set_ctl(1'b0, 1'b0, 1'b0);
    set_in(CTRL_LW, DATA_LW, 1'b1);
    tick();
    checks++;
    if (ctrl_out !== CTRL_LW) begin
      errors++; $display("FAIL load_ctrl: got %h expected %h", ctrl_out, CTRL_LW);
    end
    checks++;
    if (data_out !== DATA_LW) begin
      errors++; $display("FAIL load_data: got %h expected %h", data_out, DATA_LW);
    end
    checks++;
    if (bus.rt_out !== 5'd8 || bus.imm_out !== 32'h10 || bus.mem_to_reg_out !== 2'b01) begin
      errors++; $display("FAIL load_fields: got rt=%0d imm=%h m2r=%b expected 8 10 01",
                         bus.rt_out, bus.imm_out, bus.mem_to_reg_out);
    end
    checks++;
    if (bus.ex_valid !== 1'b1) begin
      errors++; $display("FAIL load_ex_valid: got %b expected 1", bus.ex_valid);
    end
  endtask

  task automatic test_stall();
    set_ctl(1'b0, 1'b1, 1'b0);
    set_in(CTRL_ST, DATA_A, 1'b1);
    tick();
    checks++;
    if (ctrl_out !== '0) begin
      errors++; $display("FAIL stall_ctrl: got %h expected 0", ctrl_out);
    end
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.reg_write_out !== 1'b0 || bus.mem_read_out !== 1'b0) begin
      errors++; $display("FAIL stall_valid: got v=%b rw=%b mr=%b expected 0 0 0",
                         bus.ex_valid, bus.reg_write_out, bus.mem_read_out);
    end
    checks++;
    if (data_out !== '0) begin
      errors++; $display("FAIL stall_data: got %h expected 0", data_out);
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    checks++;
    if (bubble_cnt !== 16'd1) begin
      errors++; $display("FAIL stall_bubble_cnt: got %0d expected 1", bubble_cnt);
    end
`endif
  endtask

  task automatic test_hold();
    set_ctl(1'b0, 1'b0, 1'b0);
    set_in(CTRL_A, DATA_A, 1'b1);
    tick();
    set_ctl(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_in(CTRL_B ^ CTRL_W'(i), DATA_B ^ DATA_W'(i), 1'b0);
      tick();
      checks++;
      if (ctrl_out !== CTRL_A || data_out !== DATA_A || bus.ex_valid !== 1'b1) begin
        errors++; $display("FAIL hold_keep[%0d]: got %h/%h/%b expected %h/%h/1",
                           i, ctrl_out, data_out, bus.ex_valid, CTRL_A, DATA_A);
      end
    end
    set_ctl(1'b0, 1'b0, 1'b0);
    set_in(CTRL_B, DATA_B, 1'b1);
    tick();
    checks++;
    if (ctrl_out !== CTRL_B || data_out !== DATA_B || bus.ex_valid !== 1'b1) begin
      errors++; $display("FAIL hold_release: got %h/%h/%b expected %h/%h/1",
                         ctrl_out, data_out, bus.ex_valid, CTRL_B, DATA_B);
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    checks++;
    if (bubble_cnt !== 16'd1) begin
      errors++; $display("FAIL hold_bubble_cnt: got %0d expected 1", bubble_cnt);
    end
`endif
  endtask

  task automatic test_priority();
    set_ctl(1'b1, 1'b1, 1'b1);
    set_in(CTRL_BR, DATA_A, 1'b1);
    tick();
    checks++;
    if (bus.branch_out !== 1'b0 || ctrl_out !== '0 || bus.ex_valid !== 1'b0) begin
      errors++; $display("FAIL prio_bubble: got br=%b ctrl=%h v=%b expected 0 0 0",
                         bus.branch_out, ctrl_out, bus.ex_valid);
    end
    set_ctl(1'b0, 1'b0, 1'b1);
    set_in(CTRL_A, DATA_A, 1'b1);
    tick();
    checks++;
    if (ctrl_out !== '0 || data_out !== '0 || bus.ex_valid !== 1'b0) begin
      errors++; $display("FAIL prio_hold_bubble: got %h/%h/%b expected 0/0/0",
                         ctrl_out, data_out, bus.ex_valid);
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    checks++;
    if (bubble_cnt !== 16'd2) begin
      errors++; $display("FAIL prio_bubble_cnt: got %0d expected 2", bubble_cnt);
    end
`endif
  endtask

  task automatic test_flush_stall_hold();
    set_ctl(1'b0, 1'b0, 1'b0);
    set_in(CTRL_A, DATA_A, 1'b1);
    tick();
    set_ctl(1'b1, 1'b0, 1'b1);
    tick();
    checks++;
    if (ctrl_out !== '0 || bus.ex_valid !== 1'b0) begin
      errors++; $display("FAIL flush_hold: got ctrl=%h v=%b expected 0 0", ctrl_out, bus.ex_valid);
    end
    set_ctl(1'b0, 1'b0, 1'b0);
    set_in(CTRL_B, DATA_B, 1'b1);
    tick();
    set_ctl(1'b0, 1'b1, 1'b1);
    tick();
    checks++;
    if (ctrl_out !== '0 || bus.ex_valid !== 1'b0 || bus.mem_write_out !== 1'b0) begin
      errors++; $display("FAIL stall_hold: got ctrl=%h v=%b expected 0 0", ctrl_out, bus.ex_valid);
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    checks++;
    if (bubble_cnt !== 16'd4) begin
      errors++; $display("FAIL fsh_bubble_cnt: got %0d expected 4", bubble_cnt);
    end
`endif
  endtask

  task automatic test_invalid_load();
    set_ctl(1'b0, 1'b0, 1'b0);
    set_in(CTRL_A, DATA_B, 1'b0);
    tick();
    checks++;
    if (ctrl_out !== CTRL_A || data_out !== DATA_B || bus.ex_valid !== 1'b0) begin
      errors++; $display("FAIL invalid_load: got %h/%h/%b expected %h/%h/0",
                         ctrl_out, data_out, bus.ex_valid, CTRL_A, DATA_B);
    end
  endtask

  task automatic test_reset_mid_hold();
    set_ctl(1'b0, 1'b0, 1'b0);
    set_in(CTRL_B, DATA_A, 1'b1);
    tick();
    set_ctl(1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl_out !== '0 || data_out !== '0 || bus.ex_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_hold: got %h/%h/%b expected 0/0/0",
                         ctrl_out, data_out, bus.ex_valid);
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    checks++;
    if (bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_mid_hold_cnt: got %0d expected 0", bubble_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (ctrl_out !== '0 || data_out !== '0) begin
      errors++; $display("FAIL post_reset_hold: got %h/%h expected 0/0", ctrl_out, data_out);
    end
    set_ctl(1'b0, 1'b0, 1'b0);
  endtask

`ifdef ID_EX_BUBBLE_CNT_EN
  task automatic test_saturation();
    set_ctl(1'b0, 1'b1, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_cnt: got %h expected ffff", bubble_cnt);
    end
    set_ctl(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bubble_cnt !== 16'h0) begin
      errors++; $display("FAIL sat_reset: got %h expected 0", bubble_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_load();
    test_stall();
    test_hold();
    test_priority();
    test_flush_stall_hold();
    test_invalid_load();
    test_reset_mid_hold();
`ifdef ID_EX_BUBBLE_CNT_EN
    test_saturation();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
